// File: rtl/jesd204_rx_header_lock_ctrl_pkg.sv
// Shared jesd204 receive definitions: lock FSM states and 64b66b sync-header helpers.
package jesd204_rx_header_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP      = 2'd1,
        ST_SLIP_WAIT = 2'd2,
        ST_LOCKED    = 2'd3
    } lock_state_e;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // A sync header is legal only when its two bits differ.
    function automatic logic is_valid_hdr(input logic [1:0] hdr);
        return hdr[1] ^ hdr[0];
    endfunction

endpackage

// File: rtl/jesd204_rx_header_lock_ctrl.sv
// 64b66b sync-header lock controller: slips the GT gearbox until headers align,
// declares block lock, and drops lock when too many bad headers land in one window.
module jesd204_rx_header_lock_ctrl
    import jesd204_rx_header_lock_ctrl_pkg::*;
#(
    parameter int unsigned GOOD_LOCK_CNT = 64,
    parameter int unsigned BAD_LIMIT     = 16,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned SLIP_WAIT     = 32
) (
    input  logic       usr_clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       header_valid,
    input  logic [1:0] header,
    output logic       slip,
    output logic       block_sync,
    output logic       lock_lost,
    output logic [7:0] slip_count
);

    localparam int unsigned GOOD_W = $clog2(GOOD_LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [GOOD_W-1:0] GOOD_TERM = GOOD_W'(GOOD_LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_TERM  = BAD_W'(BAD_LIMIT);
    localparam logic [WIN_W-1:0]  WIN_TERM  = WIN_W'(WINDOW);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    lock_state_e       r_state;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [BAD_W-1:0]  r_bad_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_slip;
    logic              r_block_sync;
    logic              r_lock_lost;
    logic [7:0]        r_slip_count;
    logic              r_enable_d;

    logic              w_hdr_ok;
    logic [GOOD_W-1:0] w_good_next;
    logic [BAD_W-1:0]  w_bad_next;
    logic [WIN_W-1:0]  w_win_next;
    logic [7:0]        w_slip_base;
    logic [7:0]        w_slip_inc;

    always_comb begin
        w_hdr_ok    = is_valid_hdr(header);
        w_good_next = (r_good_cnt == GOOD_TERM) ? r_good_cnt : r_good_cnt + 1'b1;
        w_win_next  = (r_win_cnt == WIN_TERM) ? r_win_cnt : r_win_cnt + 1'b1;
        w_bad_next  = (r_bad_cnt == BAD_TERM) ? r_bad_cnt : r_bad_cnt + BAD_W'(!w_hdr_ok);
        // Rising enable restarts the slip tally; a slip issued on that same edge still counts.
        w_slip_base = (enable && !r_enable_d) ? '0 : r_slip_count;
        w_slip_inc  = (w_slip_base == 8'hFF) ? 8'hFF : w_slip_base + 8'd1;
    end

    always_ff @(posedge usr_clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_HUNT;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_win_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_slip       <= 1'b0;
            r_block_sync <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_slip_count <= '0;
            r_enable_d   <= 1'b0;
        end else begin
            r_enable_d   <= enable;
            r_slip       <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_slip_count <= w_slip_base;
            if (!enable) begin
                r_state      <= ST_HUNT;
                r_good_cnt   <= '0;
                r_bad_cnt    <= '0;
                r_win_cnt    <= '0;
                r_wait_cnt   <= '0;
                r_block_sync <= 1'b0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (header_valid) begin
                            if (!w_hdr_ok) begin
                                r_good_cnt   <= '0;
                                r_state      <= ST_SLIP;
                                r_slip       <= 1'b1;
                                r_slip_count <= w_slip_inc;
                            end else if (w_good_next == GOOD_TERM) begin
                                r_good_cnt   <= '0;
                                r_win_cnt    <= '0;
                                r_bad_cnt    <= '0;
                                r_state      <= ST_LOCKED;
                                r_block_sync <= 1'b1;
                            end else begin
                                r_good_cnt <= w_good_next;
                            end
                        end
                    end
                    ST_SLIP: begin
                        r_state    <= ST_SLIP_WAIT;
                        r_wait_cnt <= WAIT_LOAD;
                    end
                    ST_SLIP_WAIT: begin
                        if (r_wait_cnt <= WAIT_ONE) begin
                            r_wait_cnt <= '0;
                            r_good_cnt <= '0;
                            r_state    <= ST_HUNT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // The bad-header limit is tested on the incremented count, ahead of the window clear.
                        if (header_valid) begin
                            if (w_bad_next == BAD_TERM) begin
                                r_state      <= ST_SLIP;
                                r_slip       <= 1'b1;
                                r_lock_lost  <= 1'b1;
                                r_block_sync <= 1'b0;
                                r_slip_count <= w_slip_inc;
                                r_win_cnt    <= '0;
                                r_bad_cnt    <= '0;
                            end else if (w_win_next == WIN_TERM) begin
                                r_win_cnt <= '0;
                                r_bad_cnt <= '0;
                            end else begin
                                r_win_cnt <= w_win_next;
                                r_bad_cnt <= w_bad_next;
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign slip       = r_slip;
    assign block_sync = r_block_sync;
    assign lock_lost  = r_lock_lost;
    assign slip_count = r_slip_count;

endmodule

// File: tb/tb_jesd204_rx_header_lock_ctrl.sv
// Directed bench for the sync-header lock controller with a per-cycle expectation queue.
module tb_jesd204_rx_header_lock_ctrl;
    import jesd204_rx_header_lock_ctrl_pkg::*;

    localparam int GLC = 64;
    localparam int BL  = 16;
    localparam int WIN = 64;
    localparam int SW  = 32;

    localparam logic [1:0] BAD0 = 2'b00;
    localparam logic [1:0] BAD1 = 2'b11;

    logic       usr_clk;
    logic       resetn;
    logic       enable;
    logic       header_valid;
    logic [1:0] header;
    logic       slip;
    logic       block_sync;
    logic       lock_lost;
    logic [7:0] slip_count;

    typedef struct {
        string      tag;
        logic       s;
        logic       bs;
        logic       ll;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_slip = -1;

    jesd204_rx_header_lock_ctrl #(
        .GOOD_LOCK_CNT(GLC),
        .BAD_LIMIT    (BL),
        .WINDOW       (WIN),
        .SLIP_WAIT    (SW)
    ) dut (
        .usr_clk     (usr_clk),
        .resetn      (resetn),
        .enable      (enable),
        .header_valid(header_valid),
        .header      (header),
        .slip        (slip),
        .block_sync  (block_sync),
        .lock_lost   (lock_lost),
        .slip_count  (slip_count)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    function automatic logic [1:0] good_hdr(input int i);
        return (i % 2 == 1) ? HDR_CTRL : HDR_DATA;
    endfunction

    function automatic logic [1:0] bad_hdr(input int i);
        return (i % 2 == 1) ? BAD1 : BAD0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_push(input string tag, input logic s, input logic bs, input logic ll,
                           input logic [7:0] cnt);
        exp_t item;
        item.tag = tag;
        item.s   = s;
        item.bs  = bs;
        item.ll  = ll;
        item.cnt = cnt;
        sb.push_back(item);
    endtask

    // Drive one header, clock it in, then compare outputs against the queued expectation.
    task automatic cycle(input logic v, input logic [1:0] h);
        exp_t item;
        header_valid = v;
        header       = h;
        @(posedge usr_clk);
        #1;
        cyc++;
        if (slip) begin
            if (last_slip >= 0) chk("slip_spacing", 32'((cyc - last_slip) >= SW + 2), 32'd1);
            last_slip = cyc;
        end
        if (sb.size() > 0) begin
            item = sb.pop_front();
            chk({item.tag, ".slip"}, slip, item.s);
            chk({item.tag, ".block_sync"}, block_sync, item.bs);
            chk({item.tag, ".lock_lost"}, lock_lost, item.ll);
            chk({item.tag, ".slip_count"}, slip_count, item.cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int prev;
        int expc;

        resetn       = 1'b0;
        enable       = 1'b1;
        header_valid = 1'b0;
        header       = 2'b00;
        repeat (3) @(posedge usr_clk);
        #1;
        chk("reset.slip", slip, 0);
        chk("reset.block_sync", block_sync, 0);
        chk("reset.lock_lost", lock_lost, 0);
        chk("reset.slip_count", slip_count, 0);
        resetn = 1'b1;

        // Clean alignment: lock right after the 64th header, no slip.
        for (int i = 0; i < GLC; i++) begin
            sb_push("lock_clean", 0, (i == GLC - 1), 0, 8'd0);
            cycle(1'b1, good_hdr(i));
        end

        enable = 1'b0;
        sb_push("en_low_drop", 0, 0, 0, 8'd0);
        cycle(1'b1, HDR_DATA);
        enable = 1'b1;

        // Invalid header at index 10.
        for (int i = 0; i < 10; i++) begin
            sb_push("hunt_pre_bad", 0, 0, 0, 8'd0);
            cycle(1'b1, good_hdr(i));
        end
        sb_push("first_slip", 1, 0, 0, 8'd1);
        cycle(1'b1, BAD0);
        for (int i = 0; i < SW + 1; i++) begin
            sb_push("slip_wait_ignore", 0, 0, 0, 8'd1);
            cycle(1'b1, bad_hdr(i));
        end
        for (int i = 0; i < GLC; i++) begin
            sb_push("relock1", 0, (i == GLC - 1), 0, 8'd1);
            cycle(1'b1, good_hdr(i));
        end

        // Window 1: 15 bad headers plus idle cycles carrying bad data.
        for (int i = 0; i < WIN; i++) begin
            if (i == 20) begin
                for (int k = 0; k < 3; k++) begin
                    sb_push("idle_no_count", 0, 1, 0, 8'd1);
                    cycle(1'b0, BAD1);
                end
            end
            sb_push("win1_15bad", 0, 1, 0, 8'd1);
            cycle(1'b1, (i < BL - 1) ? bad_hdr(i) : good_hdr(i));
        end
        for (int i = 0; i < WIN; i++) begin
            sb_push("win2_15bad", 0, 1, 0, 8'd1);
            cycle(1'b1, (i < BL - 1) ? bad_hdr(i) : good_hdr(i));
        end
        for (int i = 0; i < BL; i++) begin
            if (i == BL - 1) sb_push("win3_lost", 1, 0, 1, 8'd2);
            else             sb_push("win3_hold", 0, 1, 0, 8'd1);
            cycle(1'b1, bad_hdr(i));
        end
        sb_push("lost_pulse_end", 0, 0, 0, 8'd2);
        cycle(1'b1, BAD0);
        for (int i = 0; i < SW; i++) begin
            sb_push("wait2", 0, 0, 0, 8'd2);
            cycle(1'b1, bad_hdr(i));
        end
        for (int i = 0; i < GLC; i++) begin
            sb_push("relock2", 0, (i == GLC - 1), 0, 8'd2);
            cycle(1'b1, good_hdr(i));
        end

        // 16th bad header is the window-closing header.
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN - 1)    sb_push("limit_beats_clear", 1, 0, 1, 8'd3);
            else                 sb_push("edge_hold", 0, 1, 0, 8'd2);
            cycle(1'b1, (i >= WIN - BL) ? bad_hdr(i) : good_hdr(i));
        end

        // Persistent invalid headers: 300 more slips, counter saturates.
        n    = 0;
        prev = cyc;
        expc = 3;
        for (int k = 0; k < 300 * (SW + 8) && n < 300; k++) begin
            cycle(1'b1, BAD0);
            if (slip) begin
                n++;
                expc = (expc == 255) ? 255 : expc + 1;
                chk("sat_slip_count", slip_count, expc);
                chk("sat_spacing", cyc - prev, SW + 2);
                prev = cyc;
            end
        end
        chk("sat_slips_done", n, 300);
        chk("sat_final", slip_count, 255);

        // slip_count holds while disabled and clears when enable rises.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_push("dis_hold", 0, 0, 0, 8'd255);
            cycle(1'b1, BAD1);
        end
        enable = 1'b1;
        for (int i = 0; i < GLC; i++) begin
            sb_push("en_rise_lock", 0, (i == GLC - 1), 0, 8'd0);
            cycle(1'b1, good_hdr(i));
        end
        enable = 1'b0;
        sb_push("locked_en_drop", 0, 0, 0, 8'd0);
        cycle(1'b1, HDR_DATA);
        enable = 1'b1;
        sb_push("hunt_again", 0, 0, 0, 8'd0);
        cycle(1'b1, HDR_CTRL);
        sb_push("slip_before_rst", 1, 0, 0, 8'd1);
        cycle(1'b1, BAD1);

        // Asynchronous reset in the middle of the slip cycle.
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst.slip", slip, 0);
        chk("async_rst.block_sync", block_sync, 0);
        chk("async_rst.lock_lost", lock_lost, 0);
        chk("async_rst.slip_count", slip_count, 0);
        last_slip = -1;
        @(posedge usr_clk);
        #1;
        resetn = 1'b1;
        chk("queue_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
